// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit_pkg
// Brief  : Shared types and constants for the RV32M multiply/divide unit.
// Rev    : 1.0
// ============================================================================
package ex_muldiv_unit_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
// Module : muldiv_iter_core
// Brief  : Unsigned shift-add multiply / restoring divide, one bit per step.
// Rev    : 1.0
// ============================================================================
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_last,
  output logic [2*XLEN-1:0] o_prod_next,
  output logic [XLEN-1:0]   o_quot_next,
  output logic [XLEN-1:0]   o_rem_next
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hi;    // product high half / partial remainder
  logic [XLEN-1:0] r_lo;    // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] r_opnd;  // multiplicand / divisor

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_next;
  logic [XLEN-1:0] w_lo_next;

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (i_is_div) begin
      // A clear borrow bit means the divisor fits: keep the difference.
      if (!w_diff[XLEN]) begin
        w_hi_next = w_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_shift[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_next = w_sum[XLEN:1];
      w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= i_a;
      r_opnd  <= i_b;
    end else if (i_step) begin
      r_count <= r_count + 1'b1;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  assign o_last      = (r_count == CW'(XLEN - 1));
  assign o_prod_next = {w_hi_next, w_lo_next};
  assign o_quot_next = w_lo_next;
  assign o_rem_next  = w_hi_next;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit
// Brief  : Iterative RV32M multiply/divide for EX; stalls F/D/E while busy.
// Rev    : 1.0
// ============================================================================
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  input  logic            i_ex_hold,
  output logic [XLEN-1:0] o_result,
  output logic            o_done,
  output logic            o_stall
);

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   r_state;
  logic [2:0]      r_f3;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic            r_done;

  logic            w_signed_a, w_signed_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div0, w_ovf, w_start, w_step, w_last;
  logic [XLEN-1:0] w_special_res, w_calc_res;
  logic [2*XLEN-1:0] w_prod_next, w_prod_fix;
  logic [XLEN-1:0] w_quot_next, w_rem_next, w_quot_fix, w_rem_fix;

  assign w_signed_a = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                      (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
  assign w_signed_b = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) ||
                      (i_funct3 == F3_REM);
  assign w_neg_a    = w_signed_a && i_op_a[XLEN-1];
  assign w_neg_b    = w_signed_b && i_op_b[XLEN-1];
  assign w_abs_a    = w_neg_a ? (~i_op_a + 1'b1) : i_op_a;
  assign w_abs_b    = w_neg_b ? (~i_op_b + 1'b1) : i_op_b;

  assign w_div0 = i_funct3[2] && (i_op_b == '0);
  assign w_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                  (i_op_a == C_MIN_NEG) && (i_op_b == {XLEN{1'b1}});
  // funct3[1] selects the remainder flavour of the divide ops.
  assign w_special_res = w_div0 ? (i_funct3[1] ? i_op_a : {XLEN{1'b1}})
                                : (i_funct3[1] ? {XLEN{1'b0}} : C_MIN_NEG);

  assign w_start = (r_state == IDLE) && i_valid && !i_flush;
  assign w_step  = (r_state == CALC) && !i_flush;

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_start),
    .i_step      (w_step),
    .i_is_div    (r_f3[2]),
    .i_a         (w_abs_a),
    .i_b         (w_abs_b),
    .o_last      (w_last),
    .o_prod_next (w_prod_next),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  assign w_prod_fix = r_neg_q ? (~w_prod_next + 1'b1) : w_prod_next;
  assign w_quot_fix = r_neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
  assign w_rem_fix  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  always_comb begin
    w_calc_res = w_prod_fix[XLEN-1:0];
    case (r_f3)
      F3_MUL:                      w_calc_res = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             w_calc_res = w_quot_fix;
      default:                     w_calc_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_f3    <= i_funct3;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            if (w_div0 || w_ovf) begin
              r_state  <= DONE;
              r_result <= w_special_res;
              r_done   <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            r_state <= IDLE;
          end else if (w_last) begin
            r_state  <= DONE;
            r_result <= w_calc_res;
            r_done   <= 1'b1;
          end
        end
        DONE: begin
          if (i_flush || !i_ex_hold) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_done   = r_done;
  assign o_stall  = !i_rst &&
                    (((r_state == IDLE) && i_valid && !i_flush) || (r_state == CALC));

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the Execute stage. It consumes the ID/EX register outputs: post-forwarding operands, funct3 and an M-op valid flag. While an operation is in flight it stalls the F/D/E stages through the hazard unit. The finished result goes to the EX result mux and is captured by the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; the iteration counter is clog2(XLEN)+1 bits wide.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_valid  in  1  the instruction currently in EX is an M-extension op (from the ID/EX register).
i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
i_op_a  in  XLEN  rs1 operand after forwarding.
i_op_b  in  XLEN  rs2 operand after forwarding.
i_flush  in  1  FlushE; aborts the operation in flight.
i_ex_hold  in  1  downstream stall; EX/MEM cannot accept this cycle.
o_result  out  XLEN  registered result; meaningful only while o_done=1.
o_done  out  1  result valid; high exactly while state==DONE.
o_stall  out  1  stall request to the hazard unit (combinational).

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, o_result=0, o_done=0, all internal accumulators=0. o_stall is forced to 0 while i_rst=1.
- o_stall = (IDLE & i_valid & !i_flush) | CALC. o_stall is 0 in DONE, so the pipeline advances on the edge after the result becomes valid.
- IDLE:
  - i_flush=1: stay in IDLE (flush wins over i_valid).
  - i_valid=1: latch funct3, absolute values of the operands (signed per funct3: MULH/DIV/REM take signed a and b; MULHSU takes signed a, unsigned b), and the result sign.
  - Then: divide-by-zero or signed overflow (0x80000000 / -1) -> DONE directly with the special result. Otherwise -> CALC with count=0.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, count 0..XLEN-1. After the step at count=XLEN-1, go to DONE and register the sign-corrected result.
  - Any cycle with i_flush=1 -> IDLE; partial state is discarded and o_done is never asserted.
- DONE:
  - i_flush=1 -> IDLE.
  - i_ex_hold=1 -> stay in DONE with o_result stable.
  - Otherwise -> IDLE unconditionally, even if i_valid is still high: that instruction leaves EX on this edge.
- Latency (normal op): start cycle plus XLEN CALC cycles = XLEN+1 stall cycles (33). DONE follows on the next cycle. Special cases: 1 stall cycle, then DONE.
- Results:
  - MUL: low XLEN bits of the 2*XLEN product.
  - MULH/MULHSU/MULHU: high XLEN bits, negated as a full 2*XLEN value when the sign requires it.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
- Division by zero: quotient = all ones; remainder = dividend, unchanged.
- Signed overflow: quotient = 0x80000000, remainder = 0.
- The product is 2*XLEN bits internally. Remainder register is XLEN+1 bits for the subtract-compare. No truncation before sign correction.
- Back-to-back M-ops: a new start is accepted in the IDLE cycle immediately following DONE.
- Reset asserted mid-CALC: outputs drop to reset values asynchronously. No result is produced after reset is released.

Decomposition:
- Shared package:
  - muldiv_state_e enum {IDLE, CALC, DONE};
  - funct3 localparams F3_MUL..F3_REMU;
  - XLEN default constant.
- One natural sub-module: muldiv_iter_core, the unsigned shift-add / restoring-divide datapath with its step counter. The top holds the FSM, operand sign handling, special cases and the result register.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD -> o_result=0xFFFFFFEB; o_stall high for exactly 33 cycles; o_done high for 1 cycle.
2. Multiply-high cases:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
3. Division cases:
   - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
   - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Special cases (each: 1 stall cycle, then o_done):
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
5. Start DIVU, assert i_flush at count=10 -> IDLE next cycle, o_stall=0, o_done never asserted; a following MUL 3*4 -> 12.
6. Hold and reset:
   - i_ex_hold=1 for 3 cycles in DONE -> o_done and o_result (MUL 6*7=42) held 4 cycles, then IDLE.
   - Async i_rst mid-CALC -> o_result=0, o_done=0, o_stall=0 immediately.
